// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Purpose  : Registered RISC-V immediate generator for the decode stage.
//             Decodes I/S/B/U/J, shift-amount and CSR zimm immediates,
//             extends them to XLEN and holds the result in a one-entry
//             output register with valid/ready handshake, flush and a
//             passthrough tag. An illegal select sets imm_err and bumps a
//             saturating error counter.
//  Ports    : clk, rst (async, active-low)
//             in_valid/in_ready, instr[31:0], imm_src[2:0], in_tag  - input side
//             flush                                                   - kill held entry
//             out_valid/out_ready, imm_ext[XLEN-1:0], imm_err, out_tag - output side
//             err_cnt[CNT_W-1:0]                                      - illegal-select count
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             imm_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] c_src_i     = 3'b000;
  localparam logic [2:0] c_src_s     = 3'b001;
  localparam logic [2:0] c_src_b     = 3'b010;
  localparam logic [2:0] c_src_u     = 3'b011;
  localparam logic [2:0] c_src_j     = 3'b100;
  localparam logic [2:0] c_src_shamt = 3'b101;
  localparam logic [2:0] c_src_zimm  = 3'b110;
  localparam logic [2:0] c_src_ill   = 3'b111;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic             r_out_valid;
  logic [XLEN-1:0]  r_imm_ext;
  logic             r_imm_err;
  logic [TAG_W-1:0] r_out_tag;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_accept;
  logic [31:0]      w_imm32;
  logic             w_err;
  logic [XLEN-1:0]  w_imm;
  logic             w_unused_opcode;

  // The opcode field never contributes to any immediate.
  assign w_unused_opcode = ^instr[6:0];

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Every format fits in 32 bits; build a 32-bit sign-correct value first
  // and widen it afterwards. Zero-extended formats have bit 31 clear, so
  // the common sign-extension below leaves them untouched.
  always_comb begin
    w_imm32 = 32'b0;
    w_err   = 1'b0;
    case (imm_src)
      c_src_i:     w_imm32 = {{20{instr[31]}}, instr[31:20]};
      c_src_s:     w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      c_src_b:     w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
      c_src_u:     w_imm32 = {instr[31:12], 12'b0};
      c_src_j:     w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
      c_src_shamt: begin
        if (XLEN == 64) w_imm32 = {26'b0, instr[25:20]};
        else            w_imm32 = {27'b0, instr[24:20]};
      end
      c_src_zimm:  w_imm32 = {27'b0, instr[19:15]};
      c_src_ill:   w_err   = 1'b1;
      default:     w_err   = 1'b1;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_xlen32
      assign w_imm = w_imm32;
    end
  endgenerate

  // Output register. Flush wins over everything (w_accept already excludes
  // it); a same-edge drain and load keeps out_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_imm_ext   <= '0;
      r_imm_err   <= 1'b0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_imm_ext   <= w_imm;
      r_imm_err   <= w_err;
      r_out_tag   <= in_tag;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted illegal selects; cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (w_accept && (imm_src == c_src_ill) && (r_err_cnt != c_cnt_max)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign imm_ext   = r_imm_ext;
  assign imm_err   = r_imm_err;
  assign out_tag   = r_out_tag;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_pipe
//  Purpose  : Self-checking bench for imm_gen_pipe. A 32-bit and a 64-bit
//             instance share one stimulus stream and are compared against
//             a behavioural model of the immediate formats and handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
  localparam int CNT_W = 8;
  localparam int c_cnt_max = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      instr = 32'b0;
  logic [2:0]       imm_src = 3'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;

  logic             in_ready_32, out_valid_32, imm_err_32;
  logic [31:0]      imm_ext_32;
  logic [TAG_W-1:0] out_tag_32;
  logic [CNT_W-1:0] err_cnt_32;

  logic             in_ready_64, out_valid_64, imm_err_64;
  logic [63:0]      imm_ext_64;
  logic [TAG_W-1:0] out_tag_64;
  logic [CNT_W-1:0] err_cnt_64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut_32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_32), .out_ready(out_ready), .imm_ext(imm_ext_32),
    .imm_err(imm_err_32), .out_tag(out_tag_32), .err_cnt(err_cnt_32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut_64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid_64), .out_ready(out_ready), .imm_ext(imm_ext_64),
    .imm_err(imm_err_64), .out_tag(out_tag_64), .err_cnt(err_cnt_64)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the output register
  logic             m_valid = 1'b0;
  logic [63:0]      m_imm32 = '0;
  logic [63:0]      m_imm64 = '0;
  logic             m_err   = 1'b0;
  logic [TAG_W-1:0] m_tag   = '0;
  int               m_cnt   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Immediate value from the format rules, computed as integers.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
    longint v;
    case (src)
      3'd0: v = longint'($signed(ins[31:20]));
      3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3: v = longint'($signed({ins[31:12], 12'b0}));
      3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd5: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid_32", out_valid_32, m_valid);
    check_eq("out_valid_64", out_valid_64, m_valid);
    check_eq("err_cnt_32", err_cnt_32, m_cnt);
    check_eq("err_cnt_64", err_cnt_64, m_cnt);
    if (m_valid) begin
      check_eq("imm_ext_32", imm_ext_32, m_imm32);
      check_eq("imm_ext_64", imm_ext_64, m_imm64);
      check_eq("imm_err_32", imm_err_32, m_err);
      check_eq("imm_err_64", imm_err_64, m_err);
      check_eq("out_tag_32", out_tag_32, m_tag);
      check_eq("out_tag_64", out_tag_64, m_tag);
    end
  endtask

  // One clock cycle: drive after the falling edge, check in_ready, advance
  // the model across the rising edge and check outputs 1 time unit later.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                      input logic [TAG_W-1:0] tg, input logic ordy, input logic fl);
    logic rdy_exp, acc;
    in_valid  = v;
    instr     = ins;
    imm_src   = src;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy_exp = !m_valid || ordy;
    check_eq("in_ready_32", in_ready_32, rdy_exp);
    check_eq("in_ready_64", in_ready_64, rdy_exp);
    acc = v && rdy_exp && !fl;
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_imm32 = ref_imm(ins, src, 32);
      m_imm64 = ref_imm(ins, src, 64);
      m_err   = (src == 3'b111);
      m_tag   = tg;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (acc && src == 3'b111 && m_cnt < c_cnt_max) m_cnt++;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_imm32 = '0;
    m_imm64 = '0;
    m_err   = 1'b0;
    m_tag   = '0;
    m_cnt   = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, {out_valid_32, out_valid_64}, 2'b00);
    check_eq({tag, "_imm32"}, imm_ext_32, 64'h0);
    check_eq({tag, "_imm64"}, imm_ext_64, 64'h0);
    check_eq({tag, "_err"},   {imm_err_32, imm_err_64}, 2'b00);
    check_eq({tag, "_tag"},   {out_tag_32, out_tag_64}, '0);
    check_eq({tag, "_cnt"},   {err_cnt_32, err_cnt_64}, '0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all_zero("reset");
    rst = 1'b1;

    // 1. I-format, first accept right after reset release
    step(1'b1, 32'hFFF00093, 3'b000, 5'd1, 1'b1, 1'b0);
    check_eq("t1_imm32", imm_ext_32, 64'hFFFFFFFF);
    check_eq("t1_imm64", imm_ext_64, 64'hFFFFFFFFFFFFFFFF);
    check_eq("t1_err", imm_err_32, 1'b0);

    // 2. Back-to-back formats, one per cycle
    step(1'b1, 32'hFE512E23, 3'b001, 5'd2, 1'b1, 1'b0);
    check_eq("t2_s", imm_ext_32, 64'hFFFFFFFC);
    step(1'b1, 32'hFE000CE3, 3'b010, 5'd3, 1'b1, 1'b0);
    check_eq("t2_b", imm_ext_32, 64'hFFFFFFF8);
    step(1'b1, 32'h123450B7, 3'b011, 5'd4, 1'b1, 1'b0);
    check_eq("t2_u", imm_ext_32, 64'h12345000);
    step(1'b1, 32'hFFDFF0EF, 3'b100, 5'd5, 1'b1, 1'b0);
    check_eq("t2_j", imm_ext_32, 64'hFFFFFFFC);
    check_eq("t2_tag", out_tag_32, 5'd5);

    // 3. Backpressure: held stable, new inputs refused
    step(1'b1, 32'h00500093, 3'b000, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hFFF00093, 3'b000, 5'd7, 1'b0, 1'b0);
      check_eq("t3_in_ready", in_ready_32, 1'b0);
      check_eq("t3_hold_imm", imm_ext_32, 64'h5);
      check_eq("t3_hold_tag", out_tag_32, 5'd6);
    end
    step(1'b1, 32'h00700093, 3'b000, 5'd8, 1'b1, 1'b0);
    check_eq("t3_drain_load_valid", out_valid_32, 1'b1);
    check_eq("t3_drain_load_imm", imm_ext_32, 64'h7);

    // 4. Flush kills the held entry and drops an illegal input uncounted
    step(1'b1, 32'h00100093, 3'b000, 5'd9, 1'b0, 1'b0);
    step(1'b1, 32'h00000000, 3'b111, 5'd10, 1'b0, 1'b1);
    check_eq("t4_valid", out_valid_32, 1'b0);
    check_eq("t4_cnt", err_cnt_32, 8'd0);

    // 5. Illegal select, counter saturation, then async reset mid-cycle
    for (int i = 0; i < 260; i++)
      step(1'b1, $urandom, 3'b111, TAG_W'(i), 1'b1, 1'b0);
    check_eq("t5_imm", imm_ext_32, 64'h0);
    check_eq("t5_err", imm_err_32, 1'b1);
    check_eq("t5_cnt_sat", err_cnt_32, 8'd255);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("t5_async_rst");
    @(negedge clk);
    rst = 1'b1;

    // 6. 64-bit U and SHAMT (32-bit instance checked alongside)
    step(1'b1, 32'h800000B7, 3'b011, 5'd11, 1'b1, 1'b0);
    check_eq("t6_u64", imm_ext_64, 64'hFFFFFFFF80000000);
    check_eq("t6_u32", imm_ext_32, 64'h80000000);
    step(1'b1, 32'h03F09093, 3'b101, 5'd12, 1'b1, 1'b0);
    check_eq("t6_shamt64", imm_ext_64, 64'h3F);
    check_eq("t6_shamt32", imm_ext_32, 64'h1F);
    step(1'b1, 32'h000FD073, 3'b110, 5'd13, 1'b1, 1'b0);
    check_eq("t6_zimm", imm_ext_64, 64'h1F);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
           TAG_W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
